// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and helpers for the RV32M sequencer.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b00001;
  localparam logic [4:0] OP_MULH   = 5'b00101;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01001;
  localparam logic [4:0] OP_DIV    = 5'b10001;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b11001;
  localparam logic [4:0] OP_REMU   = 5'b11101;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, FIN} state_t;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself (correct as unsigned).
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step (
  input  logic [32:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic        q_o
);

  logic [33:0] trial;
  logic [32:0] diff;

  // Partial remainder stays below the divisor, so a kept difference fits in 33 bits.
  always_comb begin
    trial = {rem_i, bit_i};
    diff  = trial[32:0] - {1'b0, divisor_i};
    q_o   = (trial >= {2'b00, divisor_i});
    rem_o = q_o ? diff : trial[32:0];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M EX-stage sequencer: 2-cycle multiply, 34-cycle restoring divide, 1-cycle special divides.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [4:0]  ALU_OP,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        DONE,
  output logic [31:0] RESULT
);

  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [63:0]       product;
  logic [32:0]       rem;
  logic [31:0]       quot;
  logic [31:0]       divisor;
  logic              lo_q, rem_q, neg_q, neg_r;

  // Decode of the incoming op (only meaningful in IDLE)
  logic        accept, is_mul, is_rem, sgn_div, div0, ovf, special;
  logic        sa, sb;
  logic [32:0] ma, mb;
  logic [63:0] prod_c;
  logic [31:0] spec_val;
  logic [32:0] rem_n;
  logic        q_bit;

  // Operand decode, product and special-case result
  always_comb begin
    accept   = START & ALU_OP[0] & ~FLUSH;
    is_mul   = ~ALU_OP[4];
    is_rem   = ALU_OP[3];
    sgn_div  = (ALU_OP == OP_DIV) || (ALU_OP == OP_REM);
    div0     = (DATA2 == 32'd0);
    ovf      = sgn_div && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
    special  = div0 | ovf;
    sa       = (ALU_OP == OP_MULH) || (ALU_OP == OP_MULHSU);
    sb       = (ALU_OP == OP_MULH);
    ma       = {sa & DATA1[31], DATA1};
    mb       = {sb & DATA2[31], DATA2};
    prod_c   = $signed({{31{ma[32]}}, ma}) * $signed({{31{mb[32]}}, mb});
    if (div0) spec_val = is_rem ? DATA1 : 32'hFFFF_FFFF;
    else      spec_val = is_rem ? 32'd0 : 32'h8000_0000;
  end

  div_step u_div_step (
    .rem_i     (rem),
    .bit_i     (quot[31]),
    .divisor_i (divisor),
    .rem_o     (rem_n),
    .q_o       (q_bit)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, stall and done
  always_comb begin
    state_n = state;
    STALL   = 1'b0;
    DONE    = 1'b0;
    case (state)
      IDLE: begin
        STALL = accept;
        if (accept) begin
          if (is_mul)       state_n = MUL;
          else if (special) state_n = FIN;
          else              state_n = DIV;
        end
      end
      MUL: begin
        STALL   = 1'b1;
        state_n = FLUSH ? IDLE : FIN;
      end
      DIV: begin
        STALL = 1'b1;
        if (FLUSH)              state_n = IDLE;
        else if (cnt == '0)     state_n = FIX;
      end
      FIX: begin
        STALL   = 1'b1;
        state_n = FLUSH ? IDLE : FIN;
      end
      FIN: begin
        DONE    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt     <= '0;
      product <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      lo_q    <= 1'b0;
      rem_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      RESULT  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          lo_q    <= (ALU_OP == OP_MUL);
          rem_q   <= is_rem;
          neg_q   <= sgn_div & (DATA1[31] ^ DATA2[31]);
          neg_r   <= sgn_div & DATA1[31];
          product <= prod_c;
          rem     <= '0;
          quot    <= abs32(DATA1, sgn_div);
          divisor <= abs32(DATA2, sgn_div);
          cnt     <= CNT_LAST;
          if (!is_mul && special) RESULT <= spec_val;
        end
        MUL: if (!FLUSH) RESULT <= lo_q ? product[31:0] : product[63:32];
        DIV: if (!FLUSH) begin
          rem  <= rem_n;
          quot <= {quot[30:0], q_bit};
          cnt  <= cnt - 1'b1;
        end
        FIX: if (!FLUSH) begin
          if (rem_q) RESULT <= neg_r ? (32'd0 - rem[31:0]) : rem[31:0];
          else       RESULT <= neg_q ? (32'd0 - quot) : quot;
        end
        default: ;
      endcase
    end
  end

endmodule
